tx_gearbox: RTL and testbench
=============================

TX_GEARBOX -- requirements
Module: tx_gearbox

Interface
REQ-001 The module SHALL have parameter HDR_WIDTH, default 2, meaning sync header width in bits; only the value 2 is supported.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning input and output word width in bits; only the value 32 is supported.
REQ-003 i_clk  input  1  single clock for all logic; one clock, no other clock domains.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_data  input  DATA_WIDTH  half of a 64-bit scrambled block payload; bit 0 is transmitted first.
REQ-006 i_hdr  input  HDR_WIDTH  sync header; sampled only when i_hdr_valid=1; bit 0 is transmitted first.
REQ-007 i_hdr_valid  input  1  high on the first word of each 66-bit block; the header precedes i_data on the line.
REQ-008 i_valid  input  1  source offers i_data/i_hdr/i_hdr_valid this cycle.
REQ-009 o_ready  output  1  gearbox accepts the offered word this cycle; transfer occurs when i_valid=1 and o_ready=1.
REQ-010 o_data  output  DATA_WIDTH  gearboxed line word; bit 0 is transmitted first.
REQ-011 o_valid  output  1  o_data holds a new line word this cycle.
REQ-012 o_hdr_err  output  1  one-cycle pulse: an accepted header was 2'b00 or 2'b11.

Function
REQ-013 The module SHALL hold a 64-bit bit buffer and a fill counter (0..32, always even) giving the number of valid buffered bits, filled from bit 0 upward.
REQ-014 The module SHALL drive o_ready combinationally as (fill != 32).
REQ-015 On accept with i_hdr_valid=1, the module SHALL append 34 bits {i_data, i_hdr} at buffer position fill, with the header in the lower bits.
REQ-016 On accept with i_hdr_valid=0, the module SHALL append 32 bits i_data at position fill.
REQ-017 Each cycle, if (fill + appended bits) >= 32, the module SHALL register the lowest 32 bits into o_data, set o_valid=1 next cycle, shift the remainder down and subtract 32 from fill.
REQ-018 If (fill + appended bits) < 32, the module SHALL set o_valid=0 next cycle, retain o_data and keep the new fill.
REQ-019 The latency from an accepted word to the o_data word containing its first bit SHALL be 1 cycle.
REQ-020 With fill=32 (o_ready=0), the module SHALL output the full buffer as one word and set fill to 0 (the pause cycle).
REQ-021 With back-to-back valid alternating input, o_ready SHALL be low exactly 1 cycle in every 33, i.e. 2 input pauses per 32 blocks, and o_valid SHALL remain 1 every cycle.
REQ-022 The module SHALL NOT check header/non-header alternation; consecutive i_hdr_valid words each append 34 bits and the buffer SHALL NOT overflow (max 30+34=64).
REQ-023 An accepted header of 2'b00 or 2'b11 SHALL pulse o_hdr_err for 1 cycle, registered, and SHALL still be transmitted unchanged.
REQ-024 Input offered while o_ready=0 SHALL be ignored; the source holds it.
REQ-025 i_valid=0 SHALL append nothing; buffered bits are not flushed until 32 bits are available.

Reset
REQ-026 Asserting i_reset_n low SHALL immediately clear fill to 0, the buffer to 0, o_data to 0, o_valid to 0 and o_hdr_err to 0, and force o_ready=1, including mid-stream; partial buffered bits are discarded.
REQ-027 After deassertion, the first accepted word SHALL be treated as buffer position 0, with no realignment cycle.

Verification
REQ-028 Reset, then accept hdr=2'b01, data=32'hFFFFFFFF (i_hdr_valid=1) -> next cycle o_valid=1, o_data=32'hFFFFFFFD, fill=2.
REQ-029 Stream 16 blocks back-to-back, i_valid=1 throughout -> o_ready=0 only on cycle 33; o_valid=1 on all 33 output cycles; line bits match the serialized {hdr,data} stream exactly.
REQ-030 Accept a header of 2'b11 -> o_hdr_err=1 for exactly one cycle; output bits contain 2'b11 at the header position.
REQ-031 Accept a header word, then hold i_valid=0 for 5 cycles -> o_valid=0 for those cycles after the first output; fill stays 2; resume -> no bits lost.
REQ-032 Assert i_reset_n low mid-stream at fill=20 -> same-cycle outputs 0, o_ready=1; after release, the first block outputs as in REQ-028.
REQ-033 Accept consecutive words all with i_hdr_valid=1 -> fill grows by 2 per word, o_ready drops at fill=32, and no overflow or data loss occurs.

Source files
------------

// File: rtl/tx_gearbox_if.sv
// Word-stream bundle between a 64b/66b block source and the TX gearbox.
// The master side offers words; the slave side returns the gearboxed line word.
interface tx_gearbox_if #(
  parameter int HDR_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic [HDR_WIDTH-1:0]  i_hdr;
  logic                  i_hdr_valid;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_hdr_err;

  modport master (
    output i_data, i_hdr, i_hdr_valid, i_valid,
    input  o_ready, o_data, o_valid, o_hdr_err
  );

  modport slave (
    input  i_data, i_hdr, i_hdr_valid, i_valid,
    output o_ready, o_data, o_valid, o_hdr_err
  );
endinterface

// File: rtl/tx_gearbox.sv
// 66b-to-32b TX gearbox: packs {data, header} words into a bit buffer and emits
// a 32-bit line word whenever 32 bits are available; pauses input when fill hits 32.
module tx_gearbox #(
  parameter int HDR_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  tx_gearbox_if.slave bus
);
  localparam int BUF_W  = 2 * DATA_WIDTH;
  localparam int FILL_W = $clog2(BUF_W) + 1;
  localparam logic [FILL_W-1:0] WORD_BITS  = FILL_W'(DATA_WIDTH);
  localparam logic [FILL_W-1:0] BLOCK_BITS = FILL_W'(DATA_WIDTH + HDR_WIDTH);

  logic [BUF_W-1:0]      bit_buf;
  logic [FILL_W-1:0]     fill;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  ready;
  logic                  accept;
  logic                  hdr_bad;
  logic [BUF_W-1:0]      app_word;
  logic [FILL_W-1:0]     app_bits;
  logic [BUF_W-1:0]      merged;
  logic [FILL_W-1:0]     total;

  // Bits above fill are always zero, so appending is a plain OR at offset fill.
  always_comb begin
    ready    = (fill != WORD_BITS);
    accept   = bus.i_valid & ready;
    app_word = '0;
    app_bits = '0;
    if (accept) begin
      if (bus.i_hdr_valid) begin
        app_word = BUF_W'({bus.i_data, bus.i_hdr});
        app_bits = BLOCK_BITS;
      end else begin
        app_word = BUF_W'(bus.i_data);
        app_bits = WORD_BITS;
      end
    end
    merged  = bit_buf | (app_word << fill);
    total   = fill + app_bits;
    hdr_bad = accept & bus.i_hdr_valid & ((bus.i_hdr == '0) | (bus.i_hdr == '1));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_buf <= '0;
      fill    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= hdr_bad;
      if (total >= WORD_BITS) begin
        data_q  <= merged[DATA_WIDTH-1:0];
        valid_q <= 1'b1;
        bit_buf <= merged >> DATA_WIDTH;
        fill    <= total - WORD_BITS;
      end else begin
        valid_q <= 1'b0;
        bit_buf <= merged;
        fill    <= total;
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_hdr_err = err_q;
endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: hand-computed vector table, directed corner sequences and
// randomized traffic against a serial bit-queue model of the transmitted line.
module tb_tx_gearbox;
  logic i_clk;
  logic i_reset_n;
  int   checks;
  int   errors;

  tx_gearbox_if #(.HDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

  tx_gearbox #(.HDR_WIDTH(2), .DATA_WIDTH(32)) u_dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Line model: every accepted bit in transmit order; a word leaves once 32 are queued.
  bit          line_q[$];
  logic [31:0] exp_data;

  typedef struct {
    logic        v;
    logic        hv;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic hv, input logic [1:0] h, input logic [31:0] d);
    bus.i_valid     = v;
    bus.i_hdr_valid = hv;
    bus.i_hdr       = h;
    bus.i_data      = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'b00, 32'h0);
    i_reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data",  bus.o_data,       32'h0);
    chk("rst_err",   32'(bus.o_hdr_err), 32'd0);
    line_q.delete();
    exp_data = '0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  // One clock of traffic checked against the line model.
  task automatic cycle(input logic v, input logic hv, input logic [1:0] h, input logic [31:0] d,
                       output logic acc, output logic rdy_seen, output logic val_seen);
    logic exp_rdy, exp_valid, exp_err;
    drive(v, hv, h, d);
    #1;
    exp_rdy  = (line_q.size() != 32);
    rdy_seen = bus.o_ready;
    chk("ready", 32'(bus.o_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (acc) begin
      if (hv) for (int i = 0; i < 2; i++) line_q.push_back(h[i]);
      for (int i = 0; i < 32; i++) line_q.push_back(d[i]);
    end
    exp_err = acc && hv && (h == 2'b00 || h == 2'b11);
    if (line_q.size() >= 32) begin
      for (int i = 0; i < 32; i++) exp_data[i] = line_q.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge i_clk);
    #1;
    val_seen = bus.o_valid;
    chk("valid", 32'(bus.o_valid), 32'(exp_valid));
    chk("data",  bus.o_data,       exp_data);
    chk("err",   32'(bus.o_hdr_err), 32'(exp_err));
  endtask

  initial begin
    logic acc, rs, vs;
    int   lows, vals, k;
    logic        pend;
    logic        p_hv;
    logic [1:0]  p_h;
    logic [31:0] p_d;
    checks = 0;
    errors = 0;
    i_reset_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0);
    #2;

    // Hand-computed vectors starting from an empty buffer.
    tbl[0] = '{1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b1, 32'h00000003, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 32'h00000000, 1'b1, 1'b0, 32'h00000003, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 2'b11, 32'h12345678, 1'b1, 1'b1, 32'h2345678C, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 2'b00, 32'hAAAAAAAA, 1'b1, 1'b1, 32'hAAAAAAA1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 2'b00, 32'h00000000, 1'b1, 1'b1, 32'h0000000A, 1'b1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].hv, tbl[i].hdr, tbl[i].data);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(bus.o_ready), 32'(tbl[i].exp_ready));
      @(posedge i_clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i),  bus.o_data,       tbl[i].exp_out);
      chk($sformatf("tbl%0d_err", i),   32'(bus.o_hdr_err), 32'(tbl[i].exp_err));
    end

    // 16 alternating blocks back-to-back: exactly one pause, output every cycle.
    do_reset();
    lows = 0; vals = 0; k = 0;
    for (int c = 0; c < 33; c++) begin
      cycle(1'b1, (k % 2) == 0, 2'b01 + 2'(k % 2), $urandom, acc, rs, vs);
      if (acc) k++;
      if (!rs) lows++;
      if (vs) vals++;
    end
    chk("b2b_pauses", lows, 1);
    chk("b2b_valids", vals, 33);
    chk("b2b_words",  k,    32);

    // Header, then five idle cycles, then resume with no bits lost.
    do_reset();
    cycle(1'b1, 1'b1, 2'b10, 32'hDEADBEEF, acc, rs, vs);
    vals = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0, 2'b00, 32'h0, acc, rs, vs);
      if (vs) vals++;
    end
    chk("idle_valids", vals, 0);
    cycle(1'b1, 1'b0, 2'b00, 32'h0F0F0F0F, acc, rs, vs);
    cycle(1'b1, 1'b1, 2'b11, 32'h55555555, acc, rs, vs);

    // Header-only words: fill rises by 2 per word until the pause at 32.
    do_reset();
    lows = 0;
    for (int c = 0; c < 17; c++) begin
      cycle(1'b1, 1'b1, 2'b01, $urandom, acc, rs, vs);
      if (!rs) lows++;
      chk($sformatf("hdr_only_ready%0d", c), 32'(rs), (c == 16) ? 32'd0 : 32'd1);
    end
    chk("hdr_only_pauses", lows, 1);
    cycle(1'b1, 1'b1, 2'b10, 32'h13579BDF, acc, rs, vs);

    // Reset mid-stream at fill=20, then the first block behaves as from power-up.
    do_reset();
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 2'b10, $urandom, acc, rs, vs);
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, acc, rs, vs);
    chk("post_rst_data", bus.o_data, 32'hFFFFFFFD);

    // Randomized traffic; the source holds an unaccepted word.
    pend = 1'b0; p_hv = 1'b0; p_h = 2'b00; p_d = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        p_hv = $urandom_range(0, 1) == 1;
        p_h  = 2'($urandom_range(0, 3));
        p_d  = $urandom;
      end
      cycle(pend, p_hv, p_h, p_d, acc, rs, vs);
      if (acc) pend = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
